// File: rtl/c7bicu_fetch_resp.sv
// ICU-side instruction-fetch responder: accepts one IFU request, performs a single
// 32-bit BIU read, and returns the word (or an error) as a one-cycle data-valid.
module c7bicu_fetch_resp #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_icu_req_ic1,
    input  logic [ADDR_W-1:0] ifu_icu_addr_ic1,
    output logic              icu_ifu_ack_ic1,
    output logic              icu_ifu_data_valid_ic2,
    output logic [DATA_W-1:0] icu_ifu_data_ic2,
    output logic              icu_ifu_err_ic2,
    output logic              icu_biu_ar_valid,
    output logic [ADDR_W-1:0] icu_biu_ar_addr,
    input  logic              biu_icu_ar_ready,
    input  logic              biu_icu_r_valid,
    input  logic [DATA_W-1:0] biu_icu_r_data,
    input  logic              biu_icu_r_err
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_AR,
        S_R,
        S_RSP
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= S_IDLE;
            addr_q                 <= '0;
            tmo_cnt                <= '0;
            drop_q                 <= 1'b0;
            icu_ifu_ack_ic1        <= 1'b0;
            icu_ifu_data_valid_ic2 <= 1'b0;
            icu_ifu_data_ic2       <= '0;
            icu_ifu_err_ic2        <= 1'b0;
            icu_biu_ar_valid       <= 1'b0;
            icu_biu_ar_addr        <= '0;
        end else begin
            icu_ifu_ack_ic1 <= 1'b0;

            // A timed-out read is still owed by the bus; its late beat is swallowed here.
            if (drop_q && biu_icu_r_valid) begin
                drop_q <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (ifu_icu_req_ic1 && !drop_q) begin
                        addr_q          <= ifu_icu_addr_ic1;
                        icu_ifu_ack_ic1 <= 1'b1;
                        state           <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (addr_q[1:0] != 2'b00) begin
                        icu_ifu_data_valid_ic2 <= 1'b1;
                        icu_ifu_data_ic2       <= '0;
                        icu_ifu_err_ic2        <= 1'b1;
                        state                  <= S_RSP;
                    end else begin
                        icu_biu_ar_valid <= 1'b1;
                        icu_biu_ar_addr  <= addr_q;
                        state            <= S_AR;
                    end
                end
                S_AR: begin
                    if (biu_icu_ar_ready) begin
                        icu_biu_ar_valid <= 1'b0;
                        tmo_cnt          <= '0;
                        state            <= S_R;
                    end
                end
                S_R: begin
                    if (biu_icu_r_valid) begin
                        icu_ifu_data_valid_ic2 <= 1'b1;
                        icu_ifu_data_ic2       <= biu_icu_r_data;
                        icu_ifu_err_ic2        <= biu_icu_r_err;
                        state                  <= S_RSP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        icu_ifu_data_valid_ic2 <= 1'b1;
                        icu_ifu_data_ic2       <= '0;
                        icu_ifu_err_ic2        <= 1'b1;
                        drop_q                 <= 1'b1;
                        state                  <= S_RSP;
                    end else if (tmo_cnt != CNT_MAX) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                S_RSP: begin
                    icu_ifu_data_valid_ic2 <= 1'b0;
                    icu_ifu_data_ic2       <= '0;
                    icu_ifu_err_ic2        <= 1'b0;
                    state                  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c7bicu_fetch_resp.sv
// Bench for c7bicu_fetch_resp: directed scenarios plus randomized fetches, each checked
// cycle by cycle against an expected-timeline model derived from the handshake rules.
module tb_c7bicu_fetch_resp;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        dv;
    logic [31:0] data;
    logic        err;
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic        r_err;

    int vecs = 0;
    int errs = 0;
    bit drop_pend = 1'b0;

    always #5 clk = ~clk;

    c7bicu_fetch_resp #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(TMO)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ifu_icu_req_ic1        (req),
        .ifu_icu_addr_ic1       (addr),
        .icu_ifu_ack_ic1        (ack),
        .icu_ifu_data_valid_ic2 (dv),
        .icu_ifu_data_ic2       (data),
        .icu_ifu_err_ic2        (err),
        .icu_biu_ar_valid       (ar_valid),
        .icu_biu_ar_addr        (ar_addr),
        .biu_icu_ar_ready       (ar_ready),
        .biu_icu_r_valid        (r_valid),
        .biu_icu_r_data         (r_data),
        .biu_icu_r_err          (r_err)
    );

    // One fetch; k counts negedges from request. late_at>=0: a dropped late beat is due first.
    // pre: request was already acked by the previous (held-request) call; hold: keep req high.
    task automatic do_txn(input string nm, input logic [31:0] a, input int ar_dly, input int r_dly,
                          input logic [31:0] d, input logic re, input int late_at,
                          input bit pre, input bit hold, input logic [31:0] next_a, input bit spur);
        int s, ack_k, ar_k0, ar_k1, k_r, k_dv, k_end;
        bit mis, tmo, e_ack, e_arv, e_dv, real_rv;
        logic [31:0] exp_d, w_d;
        logic exp_e, w_e;
        s     = (late_at >= 0) ? late_at + 1 : 0;
        ack_k = 1 + s;
        mis   = (a[1:0] != 2'b00);
        ar_k0 = 2 + s;
        ar_k1 = ar_k0 + ar_dly;
        k_r   = ar_k1 + 1;
        tmo   = !mis && (r_dly >= TMO);
        if (mis) begin
            k_dv = 2 + s; exp_d = 32'h0; exp_e = 1'b1;
        end else if (tmo) begin
            k_dv = k_r + TMO; exp_d = 32'h0; exp_e = 1'b1;
        end else begin
            k_dv = k_r + r_dly + 1; exp_d = d; exp_e = re;
        end
        k_end = k_dv + (hold ? 2 : 1);
        if (!pre) addr = a;
        for (int k = 0; k <= k_end; k++) begin
            if (k > 0 && !(pre && k == 1)) @(negedge clk);
            e_ack = (k == ack_k) || (hold && k == k_end);
            e_arv = !mis && k >= ar_k0 && k <= ar_k1;
            e_dv  = (k == k_dv);
            if (!(pre && k <= 1)) begin
                w_d = e_dv ? exp_d : 32'h0;
                w_e = e_dv ? exp_e : 1'b0;
                vecs++;
                if (ack !== e_ack) begin
                    errs++; $display("FAIL %s.ack k=%0d got=%b want=%b", nm, k, ack, e_ack);
                end
                vecs++;
                if (ar_valid !== e_arv) begin
                    errs++; $display("FAIL %s.ar_valid k=%0d got=%b want=%b", nm, k, ar_valid, e_arv);
                end
                if (e_arv) begin
                    vecs++;
                    if (ar_addr !== a) begin
                        errs++; $display("FAIL %s.ar_addr k=%0d got=%h want=%h", nm, k, ar_addr, a);
                    end
                end
                vecs++;
                if (dv !== e_dv) begin
                    errs++; $display("FAIL %s.data_valid k=%0d got=%b want=%b", nm, k, dv, e_dv);
                end
                vecs++;
                if (data !== w_d) begin
                    errs++; $display("FAIL %s.data k=%0d got=%h want=%h", nm, k, data, w_d);
                end
                vecs++;
                if (err !== w_e) begin
                    errs++; $display("FAIL %s.err k=%0d got=%b want=%b", nm, k, err, w_e);
                end
            end
            req = (k < ack_k) || hold;
            if (hold && k == k_dv) addr = next_a;
            ar_ready = !mis && (k == ar_k1);
            real_rv  = !mis && !tmo && (k == k_r + r_dly);
            r_valid  = real_rv || (k == late_at) || (spur && (e_arv || k == ack_k));
            r_data   = real_rv ? d : $urandom();
            r_err    = real_rv ? re : 1'($urandom_range(0, 1));
        end
        r_valid  = 1'b0;
        ar_ready = 1'b0;
        drop_pend = tmo;
    endtask

    task automatic check_quiet(input string nm, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            vecs++;
            if ({ack, dv, err, ar_valid} !== 4'b0000 || data !== 32'h0) begin
                errs++;
                $display("FAIL %s.quiet k=%0d got ack=%b dv=%b err=%b arv=%b data=%h want all 0",
                         nm, k, ack, dv, err, ar_valid, data);
            end
        end
    endtask

    task automatic test_reset();
        vecs++;
        if ({ack, dv, err, ar_valid} !== 4'b0000 || data !== 32'h0 || ar_addr !== 32'h0) begin
            errs++;
            $display("FAIL reset got ack=%b dv=%b err=%b arv=%b data=%h ar_addr=%h want all 0",
                     ack, dv, err, ar_valid, data, ar_addr);
        end
        reset = 1'b0;
        drop_pend = 1'b0;
        check_quiet("reset_idle", 2);
    endtask

    task automatic test_basic();
        do_txn("basic", 32'h1C00_0000, 0, 0, 32'h0280_0000, 1'b0, -1, 0, 0, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        do_txn("backpressure", 32'h1C00_0040, 5, 2, 32'hDEAD_BEEF, 1'b0, -1, 0, 0, 32'h0, 1);
        do_txn("bus_err", 32'h1C00_0044, 1, 0, 32'h1234_5678, 1'b1, -1, 0, 0, 32'h0, 0);
    endtask

    task automatic test_misaligned();
        do_txn("misaligned", 32'h1C00_0002, 0, 0, 32'h0, 1'b0, -1, 0, 0, 32'h0, 0);
        do_txn("misaligned3", 32'h1C00_0007, 0, 0, 32'h0, 1'b0, -1, 0, 0, 32'h0, 0);
    endtask

    task automatic test_timeout();
        do_txn("timeout", 32'h1C00_0100, 0, 99, 32'h0, 1'b0, -1, 0, 0, 32'h0, 0);
        do_txn("after_timeout", 32'h1C00_0104, 1, 1, 32'hCAFE_0001, 1'b0, 4, 0, 0, 32'h0, 0);
        do_txn("last_cycle_ok", 32'h1C00_0108, 0, TMO - 1, 32'hCAFE_0002, 1'b0, -1, 0, 0, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        do_txn("flush_a", 32'h1C00_0200, 1, 2, 32'hAAAA_0001, 1'b0, -1, 0, 1, 32'h1C00_0300, 0);
        do_txn("flush_b", 32'h1C00_0300, 0, 0, 32'hBBBB_0002, 1'b0, -1, 1, 0, 32'h0, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] v;
        v = $urandom();
        if ($urandom_range(0, 4) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    task automatic test_random();
        bit prev_hold, hold, last;
        logic [31:0] a, na;
        int ard, rd, late;
        prev_hold = 1'b0;
        a = rand_addr();
        for (int i = 0; i < 40; i++) begin
            last = (i == 39);
            if (!prev_hold) a = rand_addr();
            ard  = $urandom_range(0, 4);
            rd   = last ? $urandom_range(0, TMO - 1) : $urandom_range(0, 10);
            hold = !last && !(a[1:0] == 2'b00 && rd >= TMO) && ($urandom_range(0, 2) == 0);
            late = (drop_pend && !prev_hold) ? $urandom_range(0, 3) : -1;
            na   = rand_addr();
            do_txn("random", a, ard, rd, $urandom(), 1'($urandom_range(0, 1)), late,
                   prev_hold, hold, na, 1'($urandom_range(0, 1)));
            prev_hold = hold;
            if (hold) a = na;
        end
    endtask

    // Reset while the read is outstanding (in_ar: address phase, else data phase).
    task automatic test_reset_mid(input bit in_ar);
        int rst_k;
        rst_k = in_ar ? 3 : 4;
        addr = 32'h1C00_0400;
        for (int k = 0; k <= rst_k; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) begin
                vecs++;
                if (ack !== 1'b1) begin
                    errs++; $display("FAIL reset_mid.ack got=%b want=1", ack);
                end
            end
            req      = (k < 1);
            ar_ready = !in_ar && (k == 2);
            reset    = (k == rst_k);
        end
        @(negedge clk);
        vecs++;
        if ({ack, dv, err, ar_valid} !== 4'b0000 || data !== 32'h0 || ar_addr !== 32'h0) begin
            errs++;
            $display("FAIL reset_mid got ack=%b dv=%b err=%b arv=%b data=%h ar_addr=%h want all 0",
                     ack, dv, err, ar_valid, data, ar_addr);
        end
        reset = 1'b0;
        drop_pend = 1'b0;
        r_valid = 1'b1;
        r_data  = 32'h5555_AAAA;
        check_quiet("reset_mid_stray_r", 3);
        r_valid = 1'b0;
        do_txn("after_reset", 32'h1C00_0404, 0, 1, 32'h0F0F_F0F0, 1'b0, -1, 0, 0, 32'h0, 0);
    endtask

    initial begin
        reset    = 1'b1;
        req      = 1'b0;
        addr     = 32'h0;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        r_data   = 32'h0;
        r_err    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid(1'b1);
        test_reset_mid(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
